hazard_forward_unit: RTL and testbench

ID-stage hazard and forwarding controller for the 5-stage pipelined CPU. It computes the operand-source selects that drive the EX-stage 3-to-1 operand muxes, and registers them alongside the ID/EX pipeline register so they line up with the instruction in EX. It also detects load-use hazards and runs a stall FSM that freezes PC and IF/ID while inserting bubbles into ID/EX.

---
 rtl/hazard_forward_unit.sv | 126 ++++++++++++
 tb/tb_hazard_forward_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// ID-stage forwarding-select generator and load-use stall FSM; selects are registered and valid in EX.
// Defining HFU_PERF_CNT_EN adds stall_cnt_o, a free-running count of stalled cycles.
module hazard_forward_unit #(
  parameter int REG_AW       = 5,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_regwrite_i,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              ex_valid_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              idex_bubble_o
`ifdef HFU_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  typedef enum logic {RUN, STALL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic             ex_valid_q, ex_valid_d;
  logic             hazard;
  logic             stall;

  // A load in EX only forwards from MEM/WB next cycle, so it never yields the EX/MEM select.
  logic ex_fwd_ok, mem_fwd_ok;
  assign ex_fwd_ok  = ex_regwrite_i && (ex_rd_i != '0) && !ex_memread_i;
  assign mem_fwd_ok = mem_regwrite_i && (mem_rd_i != '0);

  assign hazard = id_valid_i && ex_memread_i && ex_regwrite_i && (ex_rd_i != '0) &&
                  ((ex_rd_i == id_rs_i) || (ex_rd_i == id_rt_i));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (hazard && !flush_i) begin
          stall = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_d = STALL;
            cnt_d   = CNT_W'(STALL_CYCLES - 1);
          end
        end
      end
      STALL: begin
        stall = 1'b1;
        if (flush_i || (cnt_q == CNT_W'(1))) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    fwd_a_d    = 2'b00;
    fwd_b_d    = 2'b00;
    ex_valid_d = 1'b0;
    if (!(flush_i || stall)) begin
      if (ex_fwd_ok && (ex_rd_i == id_rs_i))        fwd_a_d = 2'b10;
      else if (mem_fwd_ok && (mem_rd_i == id_rs_i)) fwd_a_d = 2'b01;
      if (ex_fwd_ok && (ex_rd_i == id_rt_i))        fwd_b_d = 2'b10;
      else if (mem_fwd_ok && (mem_rd_i == id_rt_i)) fwd_b_d = 2'b01;
      ex_valid_d = id_valid_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      fwd_a_q    <= 2'b00;
      fwd_b_q    <= 2'b00;
      ex_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign fwd_a_sel_o   = fwd_a_q;
  assign fwd_b_sel_o   = fwd_b_q;
  assign ex_valid_o    = ex_valid_q;
  assign pc_write_o    = !stall;
  assign ifid_write_o  = !stall;
  assign idex_bubble_o = stall || flush_i;

`ifdef HFU_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      stall_cnt_q <= '0;
    else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (STALL_CYCLES=1 and 3) share stimulus and a reference model.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush, idv, exrw, exmr, memrw;
  logic [4:0] rs, rt, exrd, memrd;

  logic [1:0] a1, b1, a3, b3;
  logic       v1, pcw1, ifw1, bub1, v3, pcw3, ifw3, bub3;
`ifdef HFU_PERF_CNT_EN
  logic [31:0] sc1, sc3;
`endif

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_AW(5), .STALL_CYCLES(1), .CNT_W(3)) u1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .id_valid_i(idv),
    .id_rs_i(rs), .id_rt_i(rt), .ex_rd_i(exrd), .ex_regwrite_i(exrw),
    .ex_memread_i(exmr), .mem_rd_i(memrd), .mem_regwrite_i(memrw),
    .fwd_a_sel_o(a1), .fwd_b_sel_o(b1), .ex_valid_o(v1),
    .pc_write_o(pcw1), .ifid_write_o(ifw1), .idex_bubble_o(bub1)
`ifdef HFU_PERF_CNT_EN
    , .stall_cnt_o(sc1)
`endif
  );

  hazard_forward_unit #(.REG_AW(5), .STALL_CYCLES(3), .CNT_W(3)) u3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .id_valid_i(idv),
    .id_rs_i(rs), .id_rt_i(rt), .ex_rd_i(exrd), .ex_regwrite_i(exrw),
    .ex_memread_i(exmr), .mem_rd_i(memrd), .mem_regwrite_i(memrw),
    .fwd_a_sel_o(a3), .fwd_b_sel_o(b3), .ex_valid_o(v3),
    .pc_write_o(pcw3), .ifid_write_o(ifw3), .idex_bubble_o(bub3)
`ifdef HFU_PERF_CNT_EN
    , .stall_cnt_o(sc3)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: remaining stall cycles and expected registered outputs per instance.
  int          n_len[2] = '{1, 3};
  int          left[2];
  logic [1:0]  ea[2], eb[2];
  logic        ev[2];
  logic [31:0] nst[2];

  logic c_pcw1, c_ifw1, c_bub1, c_pcw3, c_bub3;

  typedef struct {
    logic       flush, idv;
    logic [4:0] rs, rt, exrd;
    logic       exrw, exmr;
    logic [4:0] memrd;
    logic       memrw;
    logic       pcw, bub;
    logic [1:0] a, b;
    logic       v;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_sel(input logic [4:0] src);
    if (exrw && exrd == src && exrd != 0 && !exmr) return 2'b10;
    if (memrw && memrd == src && memrd != 0)        return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      left[i] = 0; ea[i] = 2'b00; eb[i] = 2'b00; ev[i] = 1'b0; nst[i] = 0;
    end
  endtask

  task automatic set_in(input logic f, input logic d, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] er, input logic ew, input logic em,
                        input logic [4:0] mr, input logic mw);
    flush = f; idv = d; rs = s; rt = t; exrd = er; exrw = ew; exmr = em; memrd = mr; memrw = mw;
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    bit         hz;
    bit         st[2];
    logic [1:0] na, nb;
    #1;
    hz = idv && exmr && exrw && exrd != 0 && (exrd == rs || exrd == rt);
    na = ref_sel(rs);
    nb = ref_sel(rt);
    for (int i = 0; i < 2; i++) st[i] = (left[i] > 0) || (hz && !flush);
    chk("pc_write_1",   pcw1, !st[0]);
    chk("ifid_write_1", ifw1, !st[0]);
    chk("bubble_1",     bub1, st[0] || flush);
    chk("pc_write_3",   pcw3, !st[1]);
    chk("ifid_write_3", ifw3, !st[1]);
    chk("bubble_3",     bub3, st[1] || flush);
    c_pcw1 = pcw1; c_ifw1 = ifw1; c_bub1 = bub1; c_pcw3 = pcw3; c_bub3 = bub3;
    for (int i = 0; i < 2; i++) begin
      if (flush || st[i]) begin
        ea[i] = 2'b00; eb[i] = 2'b00; ev[i] = 1'b0;
      end else begin
        ea[i] = na; eb[i] = nb; ev[i] = idv;
      end
      if (flush)            left[i] = 0;
      else if (left[i] > 0) left[i] = left[i] - 1;
      else if (hz)          left[i] = n_len[i] - 1;
      if (st[i]) nst[i] = nst[i] + 1;
    end
    @(posedge clk);
    #1;
    chk("fwd_a_1", a1, ea[0]);
    chk("fwd_b_1", b1, eb[0]);
    chk("ex_valid_1", v1, ev[0]);
    chk("fwd_a_3", a3, ea[1]);
    chk("fwd_b_3", b3, eb[1]);
    chk("ex_valid_3", v3, ev[1]);
`ifdef HFU_PERF_CNT_EN
    chk("stall_cnt_1", sc1, nst[0]);
    chk("stall_cnt_3", sc3, nst[1]);
`endif
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_a1"}, a1, 0);  chk({tag, "_b1"}, b1, 0);  chk({tag, "_v1"}, v1, 0);
    chk({tag, "_a3"}, a3, 0);  chk({tag, "_b3"}, b3, 0);  chk({tag, "_v3"}, v3, 0);
    chk({tag, "_pcw3"}, pcw3, 1); chk({tag, "_ifw3"}, ifw3, 1); chk({tag, "_bub3"}, bub3, 0);
`ifdef HFU_PERF_CNT_EN
    chk({tag, "_cnt3"}, sc3, 0);
`endif
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b1, 5'd3, 5'd1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1};
    vt[1]  = '{1'b0, 1'b1, 5'd4, 5'd3, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1};
    vt[2]  = '{1'b0, 1'b1, 5'd3, 5'd3, 5'd7, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 1'b1};
    vt[3]  = '{1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1};
    vt[4]  = '{1'b0, 1'b1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 5'd5, 5'd2, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1};
    vt[6]  = '{1'b1, 1'b1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 5'd5, 5'd2, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1};
    vt[10] = '{1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
    vt[11] = '{1'b0, 1'b1, 5'd4, 5'd6, 5'd6, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0};

    // Power-on reset
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    #2;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle vectors against the STALL_CYCLES=1 instance
    for (int i = 0; i < 12; i++) begin
      set_in(vt[i].flush, vt[i].idv, vt[i].rs, vt[i].rt, vt[i].exrd,
             vt[i].exrw, vt[i].exmr, vt[i].memrd, vt[i].memrw);
      step();
      chk($sformatf("vec%0d_pcw", i),  c_pcw1, vt[i].pcw);
      chk($sformatf("vec%0d_ifw", i),  c_ifw1, vt[i].pcw);
      chk($sformatf("vec%0d_bub", i),  c_bub1, vt[i].bub);
      chk($sformatf("vec%0d_a", i),    a1, vt[i].a);
      chk($sformatf("vec%0d_b", i),    b1, vt[i].b);
      chk($sformatf("vec%0d_v", i),    v1, vt[i].v);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step(); step();

    // Three-cycle load-use stall on rt
    set_in(0, 1, 5'd1, 5'd6, 5'd6, 1, 1, 5'd0, 0);
    step();
    chk("seqA_c1_pcw3", c_pcw3, 0);
    set_in(0, 1, 5'd1, 5'd6, 5'd0, 0, 0, 5'd6, 1);
    step();
    chk("seqA_c2_pcw3", c_pcw3, 0);
    chk("seqA_c2_pcw1", c_pcw1, 1);
    step();
    chk("seqA_c3_pcw3", c_pcw3, 0);
    step();
    chk("seqA_c4_pcw3", c_pcw3, 1);
    chk("seqA_c4_b3", b3, 2'b01);
`ifdef HFU_PERF_CNT_EN
    chk("seqA_cnt3", sc3, nst[1]);
`endif

    // Flush in the second stall cycle
    set_in(0, 1, 5'd6, 5'd2, 5'd6, 1, 1, 5'd0, 0);
    step();
    chk("seqB_c1_pcw3", c_pcw3, 0);
    set_in(1, 1, 5'd6, 5'd2, 5'd0, 0, 0, 5'd6, 1);
    step();
    chk("seqB_c2_pcw3", c_pcw3, 0);
    chk("seqB_c2_bub3", c_bub3, 1);
    chk("seqB_c2_a3", a3, 0);
    chk("seqB_c2_v3", v3, 0);
    set_in(0, 1, 5'd6, 5'd2, 5'd0, 0, 0, 5'd6, 1);
    step();
    chk("seqB_c3_pcw3", c_pcw3, 1);
    chk("seqB_c3_a3", a3, 2'b01);

    // Asynchronous reset in the middle of a stall
    set_in(0, 1, 5'd5, 5'd1, 5'd5, 1, 1, 5'd0, 0);
    step();
    set_in(0, 1, 5'd3, 5'd1, 5'd3, 1, 0, 5'd0, 0);
    step();
    chk("seqC_pre_a1", a1, 2'b10);
    #2;
    chk("seqC_pre_pcw3", pcw3, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_state("seqC_rst");
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 1, 5'd3, 5'd1, 5'd3, 1, 0, 5'd0, 0);
    step();
    chk("seqC_post_pcw3", c_pcw3, 1);
    chk("seqC_post_a3", a3, 2'b10);

    // Randomized traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      set_in($urandom_range(0, 7) == 0, $urandom_range(0, 5) != 0,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
